// File: rtl/reorder_buffer_if.sv
// reorder_buffer_if: dispatch, operand query, write-back and commit bus of the
// reorder buffer.
//   master : upstream/downstream pipeline side (decoder, RS, LSB, regfile)
//   slave  : the reorder buffer itself
// Signals:
//   dec_*      dispatch request and tail index / full status
//   q_j/q_k_*  operand lookup by ROB index
//   rs_*       ALU write-back (value or resolved jump target)
//   lsb_*      load result / store-ready write-back
//   reg_*      register commit pulse
//   lsb_commit_* store commit pulse
//   flush*     misprediction recovery pulse with corrected PC
interface reorder_buffer_if #(
    parameter int ROB_WIDTH = 3
);
    logic                 dec_full;
    logic                 dec_rdy;
    logic [1:0]           dec_type;
    logic [4:0]           dec_rd;
    logic                 dec_done;
    logic [31:0]          dec_value;
    logic [31:0]          dec_pred_pc;
    logic [ROB_WIDTH-1:0] dec_rob_id;

    logic [ROB_WIDTH-1:0] q_j_id, q_k_id;
    logic                 q_j_ready, q_k_ready;
    logic [31:0]          q_j_data, q_k_data;

    logic                 rs_rdy;
    logic [ROB_WIDTH-1:0] rs_rob_id;
    logic [31:0]          rs_data;
    logic                 rs_set_jump_addr;

    logic                 lsb_rdy;
    logic [ROB_WIDTH-1:0] lsb_rob_id;
    logic [31:0]          lsb_data;

    logic                 reg_en;
    logic [4:0]           reg_rd;
    logic [31:0]          reg_data;
    logic [ROB_WIDTH-1:0] reg_rob_id;

    logic                 lsb_commit_en;
    logic [ROB_WIDTH-1:0] lsb_commit_rob_id;

    logic                 flush;
    logic [31:0]          flush_pc;

    modport master (
        input  dec_full, dec_rob_id, q_j_ready, q_k_ready, q_j_data, q_k_data,
               reg_en, reg_rd, reg_data, reg_rob_id, lsb_commit_en,
               lsb_commit_rob_id, flush, flush_pc,
        output dec_rdy, dec_type, dec_rd, dec_done, dec_value, dec_pred_pc,
               q_j_id, q_k_id, rs_rdy, rs_rob_id, rs_data, rs_set_jump_addr,
               lsb_rdy, lsb_rob_id, lsb_data
    );

    modport slave (
        output dec_full, dec_rob_id, q_j_ready, q_k_ready, q_j_data, q_k_data,
               reg_en, reg_rd, reg_data, reg_rob_id, lsb_commit_en,
               lsb_commit_rob_id, flush, flush_pc,
        input  dec_rdy, dec_type, dec_rd, dec_done, dec_value, dec_pred_pc,
               q_j_id, q_k_id, rs_rdy, rs_rob_id, rs_data, rs_set_jump_addr,
               lsb_rdy, lsb_rob_id, lsb_data
    );
endinterface

// File: rtl/reorder_buffer.sv
// reorder_buffer: in-order completion buffer. Allocates an entry per dispatched
// instruction at the tail, captures RS/LSB write-backs, retires at most one
// done entry per cycle from the head and raises a one-cycle flush when a
// mispredicted BRANCH/JALR retires.
// Ports:
//   clk_in    clock
//   rst_n_in  asynchronous active-low reset
//   rdy_in    global enable; low freezes every register
//   bus       reorder_buffer_if.slave (dispatch/query/write-back/commit)
// Optional feature: define ROB_QUERY_BYPASS_EN to forward same-cycle RS/LSB
// write-back data onto the operand query ports.
module reorder_buffer #(
    parameter int ROB_WIDTH = 3
) (
    input logic              clk_in,
    input logic              rst_n_in,
    input logic              rdy_in,
    reorder_buffer_if.slave  bus
);
    localparam int DEPTH = 1 << ROB_WIDTH;
    typedef logic [ROB_WIDTH-1:0] idx_t;
    typedef enum logic [1:0] {T_REG = 2'd0, T_BRANCH = 2'd1, T_JALR = 2'd2, T_STORE = 2'd3} rob_type_e;

    localparam idx_t             IDX_ONE = idx_t'(1);
    localparam logic [ROB_WIDTH:0] CNT_ONE = (ROB_WIDTH+1)'(1);
    localparam logic [ROB_WIDTH:0] CNT_MAX = (ROB_WIDTH+1)'(DEPTH);

    // Entry state
    logic [DEPTH-1:0] busy_q, done_q;
    rob_type_e        type_q    [DEPTH];
    logic [4:0]       rd_q      [DEPTH];
    logic [31:0]      value_q   [DEPTH];
    logic [31:0]      next_pc_q [DEPTH];
    logic [31:0]      pred_pc_q [DEPTH];
    idx_t             head_q, tail_q;
    logic [ROB_WIDTH:0] count_q, count_d;

    // Registered commit outputs
    logic        reg_en_q, lsb_commit_en_q, flush_q;
    logic [4:0]  reg_rd_q;
    logic [31:0] reg_data_q, flush_pc_q;
    idx_t        reg_rob_id_q, lsb_commit_rob_id_q;

    logic full, commit_en, flush_now, disp_en, rs_wb, lsb_wb;
    logic reg_commit, st_commit;
    rob_type_e head_type;

    assign full      = (count_q == CNT_MAX);
    assign head_type = type_q[head_q];
    assign commit_en = rdy_in && busy_q[head_q] && done_q[head_q];
    assign flush_now = commit_en && (head_type == T_BRANCH || head_type == T_JALR)
                       && (next_pc_q[head_q] != pred_pc_q[head_q]);
    assign reg_commit = commit_en && (head_type == T_REG || head_type == T_JALR)
                        && (rd_q[head_q] != 5'd0);
    assign st_commit  = commit_en && (head_type == T_STORE);
    // Dispatch is blocked while a flush is being taken or still visible
    // upstream; a slot freed by this edge's commit is not reusable until next edge.
    assign disp_en = rdy_in && bus.dec_rdy && !full && !flush_q && !flush_now;
    assign rs_wb   = rdy_in && bus.rs_rdy  && busy_q[bus.rs_rob_id]  && !flush_now;
    assign lsb_wb  = rdy_in && bus.lsb_rdy && busy_q[bus.lsb_rob_id] && !flush_now;

    always_comb begin
        count_d = count_q;
        if (disp_en && !commit_en)      count_d = count_q + CNT_ONE;
        else if (!disp_en && commit_en) count_d = count_q - CNT_ONE;
    end

    // Control state: pointers, count, busy/done
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            busy_q  <= '0;
            done_q  <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (rdy_in) begin
            if (flush_now) begin
                busy_q  <= '0;
                done_q  <= '0;
                head_q  <= '0;
                tail_q  <= '0;
                count_q <= '0;
            end else begin
                if (rs_wb)  done_q[bus.rs_rob_id]  <= 1'b1;
                if (lsb_wb) done_q[bus.lsb_rob_id] <= 1'b1;
                if (commit_en) begin
                    busy_q[head_q] <= 1'b0;
                    done_q[head_q] <= 1'b0;
                    head_q         <= head_q + IDX_ONE;
                end
                if (disp_en) begin
                    busy_q[tail_q] <= 1'b1;
                    done_q[tail_q] <= bus.dec_done;
                    tail_q         <= tail_q + IDX_ONE;
                end
                count_q <= count_d;
            end
        end
    end

    // Payload needs no reset: it is only observed while busy is set.
    // The RS write is ordered after LSB so RS wins on a same-entry collision.
    always_ff @(posedge clk_in) begin
        if (disp_en) begin
            type_q[tail_q]    <= rob_type_e'(bus.dec_type);
            rd_q[tail_q]      <= bus.dec_rd;
            value_q[tail_q]   <= bus.dec_value;
            next_pc_q[tail_q] <= bus.dec_pred_pc;
            pred_pc_q[tail_q] <= bus.dec_pred_pc;
        end
        if (lsb_wb) value_q[bus.lsb_rob_id] <= bus.lsb_data;
        if (rs_wb) begin
            if (bus.rs_set_jump_addr) next_pc_q[bus.rs_rob_id] <= bus.rs_data;
            else                      value_q[bus.rs_rob_id]   <= bus.rs_data;
        end
    end

    // Commit pulses; payload fields hold their last committed value.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            reg_en_q            <= 1'b0;
            reg_rd_q            <= '0;
            reg_data_q          <= '0;
            reg_rob_id_q        <= '0;
            lsb_commit_en_q     <= 1'b0;
            lsb_commit_rob_id_q <= '0;
            flush_q             <= 1'b0;
            flush_pc_q          <= '0;
        end else if (rdy_in) begin
            reg_en_q        <= reg_commit;
            lsb_commit_en_q <= st_commit;
            flush_q         <= flush_now;
            if (reg_commit) begin
                reg_rd_q     <= rd_q[head_q];
                reg_data_q   <= value_q[head_q];
                reg_rob_id_q <= head_q;
            end
            if (st_commit) lsb_commit_rob_id_q <= head_q;
            if (flush_now) flush_pc_q <= next_pc_q[head_q];
        end
    end

    // Operand query
    logic        q_j_ready, q_k_ready;
    logic [31:0] q_j_data, q_k_data;

    always_comb begin
        q_j_ready = busy_q[bus.q_j_id] && done_q[bus.q_j_id];
        q_j_data  = value_q[bus.q_j_id];
        q_k_ready = busy_q[bus.q_k_id] && done_q[bus.q_k_id];
        q_k_data  = value_q[bus.q_k_id];
`ifdef ROB_QUERY_BYPASS_EN
        if (busy_q[bus.q_j_id]) begin
            if (bus.rs_rdy && !bus.rs_set_jump_addr && bus.rs_rob_id == bus.q_j_id) begin
                q_j_ready = 1'b1;
                q_j_data  = bus.rs_data;
            end else if (bus.lsb_rdy && bus.lsb_rob_id == bus.q_j_id) begin
                q_j_ready = 1'b1;
                q_j_data  = bus.lsb_data;
            end
        end
        if (busy_q[bus.q_k_id]) begin
            if (bus.rs_rdy && !bus.rs_set_jump_addr && bus.rs_rob_id == bus.q_k_id) begin
                q_k_ready = 1'b1;
                q_k_data  = bus.rs_data;
            end else if (bus.lsb_rdy && bus.lsb_rob_id == bus.q_k_id) begin
                q_k_ready = 1'b1;
                q_k_data  = bus.lsb_data;
            end
        end
`endif
    end

    assign bus.dec_full          = full;
    assign bus.dec_rob_id        = tail_q;
    assign bus.q_j_ready         = q_j_ready;
    assign bus.q_j_data          = q_j_data;
    assign bus.q_k_ready         = q_k_ready;
    assign bus.q_k_data          = q_k_data;
    assign bus.reg_en            = reg_en_q;
    assign bus.reg_rd            = reg_rd_q;
    assign bus.reg_data          = reg_data_q;
    assign bus.reg_rob_id        = reg_rob_id_q;
    assign bus.lsb_commit_en     = lsb_commit_en_q;
    assign bus.lsb_commit_rob_id = lsb_commit_rob_id_q;
    assign bus.flush             = flush_q;
    assign bus.flush_pc          = flush_pc_q;
endmodule

// File: tb/tb_reorder_buffer.sv
module tb_reorder_buffer;
    localparam int W = 3;
    localparam logic [1:0] T_REG = 2'd0, T_BR = 2'd1, T_JALR = 2'd2, T_ST = 2'd3;

    logic clk_in = 1'b0;
    logic rst_n_in = 1'b0;
    logic rdy_in = 1'b1;

    reorder_buffer_if #(.ROB_WIDTH(W)) bus ();

    reorder_buffer #(.ROB_WIDTH(W)) dut (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .rdy_in   (rdy_in),
        .bus      (bus.slave)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic         reg_en;
        logic [4:0]   rd;
        logic [31:0]  data;
        logic [W-1:0] id;
        logic         st_en;
        logic [W-1:0] st_id;
        logic         fl;
        logic [31:0]  pc;
    } exp_t;

    exp_t exp_q[$];
    int n_err = 0;
    int n_chk = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic exp_t e_reg(input logic [4:0] rd, input logic [31:0] d, input logic [W-1:0] id);
        exp_t e = '{default: '0};
        e.reg_en = 1'b1; e.rd = rd; e.data = d; e.id = id;
        return e;
    endfunction

    function automatic exp_t e_st(input logic [W-1:0] id);
        exp_t e = '{default: '0};
        e.st_en = 1'b1; e.st_id = id;
        return e;
    endfunction

    function automatic exp_t e_fl(input logic [31:0] pc);
        exp_t e = '{default: '0};
        e.fl = 1'b1; e.pc = pc;
        return e;
    endfunction

    // Scoreboard: every qualified commit pulse must match the oldest expectation.
    always @(negedge clk_in) begin
        exp_t e;
        if (rst_n_in && rdy_in && (bus.reg_en || bus.lsb_commit_en || bus.flush)) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_commit", 32'({bus.reg_en, bus.lsb_commit_en, bus.flush}), 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("sb_reg_en", 32'(bus.reg_en), 32'(e.reg_en));
                if (e.reg_en) begin
                    chk("sb_reg_rd",   32'(bus.reg_rd),     32'(e.rd));
                    chk("sb_reg_data", bus.reg_data,        e.data);
                    chk("sb_reg_id",   32'(bus.reg_rob_id), 32'(e.id));
                end
                chk("sb_st_en", 32'(bus.lsb_commit_en), 32'(e.st_en));
                if (e.st_en) chk("sb_st_id", 32'(bus.lsb_commit_rob_id), 32'(e.st_id));
                chk("sb_flush", 32'(bus.flush), 32'(e.fl));
                if (e.fl) chk("sb_flush_pc", bus.flush_pc, e.pc);
            end
        end
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic disp(input logic [1:0] t, input logic [4:0] rd, input logic dn,
                        input logic [31:0] val, input logic [31:0] pc);
        bus.dec_rdy = 1'b1; bus.dec_type = t; bus.dec_rd = rd;
        bus.dec_done = dn; bus.dec_value = val; bus.dec_pred_pc = pc;
        tick();
        bus.dec_rdy = 1'b0;
    endtask

    task automatic wb_rs(input logic [W-1:0] id, input logic [31:0] d, input logic jmp);
        bus.rs_rdy = 1'b1; bus.rs_rob_id = id; bus.rs_data = d; bus.rs_set_jump_addr = jmp;
        tick();
        bus.rs_rdy = 1'b0;
    endtask

    task automatic wb_lsb(input logic [W-1:0] id, input logic [31:0] d);
        bus.lsb_rdy = 1'b1; bus.lsb_rob_id = id; bus.lsb_data = d;
        tick();
        bus.lsb_rdy = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string pfx);
        chk({pfx, "_reg_en"},   32'(bus.reg_en), 32'd0);
        chk({pfx, "_reg_rd"},   32'(bus.reg_rd), 32'd0);
        chk({pfx, "_reg_data"}, bus.reg_data, 32'd0);
        chk({pfx, "_reg_id"},   32'(bus.reg_rob_id), 32'd0);
        chk({pfx, "_st_en"},    32'(bus.lsb_commit_en), 32'd0);
        chk({pfx, "_st_id"},    32'(bus.lsb_commit_rob_id), 32'd0);
        chk({pfx, "_flush"},    32'(bus.flush), 32'd0);
        chk({pfx, "_flush_pc"}, bus.flush_pc, 32'd0);
        chk({pfx, "_full"},     32'(bus.dec_full), 32'd0);
        chk({pfx, "_rob_id"},   32'(bus.dec_rob_id), 32'd0);
    endtask

    initial begin
        bus.dec_rdy = 0; bus.dec_type = 0; bus.dec_rd = 0; bus.dec_done = 0;
        bus.dec_value = 0; bus.dec_pred_pc = 0; bus.q_j_id = 0; bus.q_k_id = 0;
        bus.rs_rdy = 0; bus.rs_rob_id = 0; bus.rs_data = 0; bus.rs_set_jump_addr = 0;
        bus.lsb_rdy = 0; bus.lsb_rob_id = 0; bus.lsb_data = 0;

        // Power-on reset
        #12;
        chk_reset_outputs("por");
        tick();
        rst_n_in = 1'b1;

        // Mid-run reset with 5 busy entries
        for (int i = 0; i < 5; i++) disp(T_REG, 5'(i + 1), 1'b0, 32'h0, 32'h0);
        chk("mr_rob_id_pre", 32'(bus.dec_rob_id), 32'd5);
        rst_n_in = 1'b0;
        #2;
        chk_reset_outputs("mr");
        chk("mr_qj_ready", 32'(bus.q_j_ready), 32'd0);
        tick();
        rst_n_in = 1'b1;

        // Fill with 8 REG, write back in reverse order, commit in order
        for (int i = 0; i < 8; i++) begin
            disp(T_REG, 5'(i + 1), 1'b0, 32'h0, 32'h0);
            exp_q.push_back(e_reg(5'(i + 1), 32'h100 + 32'(i), W'(i)));
            if (i == 6) chk("fill_not_full_7", 32'(bus.dec_full), 32'd0);
        end
        chk("fill_full_8", 32'(bus.dec_full), 32'd1);
        chk("fill_tail_wrap", 32'(bus.dec_rob_id), 32'd0);
        for (int i = 7; i >= 0; i--) wb_rs(W'(i), 32'h100 + 32'(i), 1'b0);
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("inorder_reg_en", 32'(bus.reg_en), 32'd1);
        end
        tick();
        chk("inorder_reg_en_end", 32'(bus.reg_en), 32'd0);

        // Full buffer: same-edge commit does not free a slot for dispatch
        for (int i = 0; i < 8; i++) begin
            disp(T_REG, 5'(10 + i), 1'b0, 32'h0, 32'h0);
            exp_q.push_back(e_reg(5'(10 + i), 32'h200 + 32'(i), W'(i)));
        end
        chk("full2", 32'(bus.dec_full), 32'd1);
        bus.lsb_rdy = 1'b1; bus.lsb_rob_id = 3'd1; bus.lsb_data = 32'h201;
        wb_rs(3'd0, 32'h200, 1'b0);
        bus.lsb_rdy = 1'b0;
        disp(T_REG, 5'd30, 1'b0, 32'h0, 32'h0);      // dropped: full at this edge
        chk("full_disp_dropped", 32'(bus.dec_rob_id), 32'd0);
        chk("full_after_commit", 32'(bus.dec_full), 32'd0);
        disp(T_REG, 5'd31, 1'b0, 32'h0, 32'h0);      // dispatch + commit same edge
        exp_q.push_back(e_reg(5'd31, 32'h2FF, 3'd0));
        chk("dc_tail", 32'(bus.dec_rob_id), 32'd1);
        chk("dc_full", 32'(bus.dec_full), 32'd0);
        for (int i = 2; i < 8; i++) wb_rs(W'(i), 32'h200 + 32'(i), 1'b0);
        wb_rs(3'd0, 32'h2FF, 1'b0);
        repeat (3) tick();
        chk("drain_tail", 32'(bus.dec_rob_id), 32'd1);

        // Mispredicted BRANCH flushes younger entries
        disp(T_BR, 5'd0, 1'b0, 32'h0, 32'h40);
        exp_q.push_back(e_fl(32'h80));
        disp(T_REG, 5'd20, 1'b1, 32'h111, 32'h0);
        disp(T_REG, 5'd21, 1'b1, 32'h222, 32'h0);
        disp(T_ST,  5'd0,  1'b1, 32'h0, 32'h0);
        chk("br_tail", 32'(bus.dec_rob_id), 32'd5);
        wb_rs(3'd1, 32'h80, 1'b1);
        tick();
        chk("br_flush", 32'(bus.flush), 32'd1);
        chk("br_flush_pc", bus.flush_pc, 32'h80);
        chk("br_tail_clr", 32'(bus.dec_rob_id), 32'd0);
        chk("br_full_clr", 32'(bus.dec_full), 32'd0);
        bus.q_j_id = 3'd2;
        #1;
        chk("br_young_cleared", 32'(bus.q_j_ready), 32'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("br_flush_pulse", 32'(bus.flush), 32'd0);
            chk("br_no_commit", 32'(bus.reg_en), 32'd0);
        end

        // JALR predicted ok, REG rd=0, STORE, mispredicted JALR
        disp(T_JALR, 5'd1, 1'b0, 32'h14, 32'h30);
        exp_q.push_back(e_reg(5'd1, 32'h14, 3'd0));
        disp(T_REG, 5'd0, 1'b1, 32'h5, 32'h0);
        disp(T_ST, 5'd0, 1'b0, 32'h0, 32'h0);
        exp_q.push_back(e_st(3'd2));
        disp(T_JALR, 5'd3, 1'b0, 32'h24, 32'h50);
        begin
            exp_t e = e_reg(5'd3, 32'h24, 3'd3);
            e.fl = 1'b1; e.pc = 32'h99;
            exp_q.push_back(e);
        end
        wb_rs(3'd0, 32'h30, 1'b1);
        wb_lsb(3'd2, 32'h0);
        wb_rs(3'd3, 32'h99, 1'b1);
        tick();
        chk("st_commit_en", 32'(bus.lsb_commit_en), 32'd1);
        chk("st_commit_id", 32'(bus.lsb_commit_rob_id), 32'd2);
        tick();
        chk("jalr_flush", 32'(bus.flush), 32'd1);
        chk("jalr_flush_pc", bus.flush_pc, 32'h99);
        chk("jalr_reg_en", 32'(bus.reg_en), 32'd1);
        chk("jalr_reg_rd", 32'(bus.reg_rd), 32'd3);
        tick();

        // rdy_in low freezes commit and dispatch
        disp(T_REG, 5'd7, 1'b1, 32'h77, 32'h0);
        exp_q.push_back(e_reg(5'd7, 32'h77, 3'd0));
        rdy_in = 1'b0;
        bus.dec_rdy = 1'b1; bus.dec_type = T_REG; bus.dec_rd = 5'd8; bus.dec_done = 1'b1;
        tick();
        tick();
        chk("frz_tail", 32'(bus.dec_rob_id), 32'd1);
        chk("frz_no_commit", 32'(bus.reg_en), 32'd0);
        bus.dec_rdy = 1'b0;
        rdy_in = 1'b1;
        tick();
        chk("frz_commit", 32'(bus.reg_en), 32'd1);
        chk("frz_data", bus.reg_data, 32'h77);

        // Query during write-back
        disp(T_REG, 5'd5, 1'b0, 32'h0, 32'h0);
        exp_q.push_back(e_reg(5'd5, 32'hAB, 3'd1));
        disp(T_REG, 5'd6, 1'b0, 32'h0, 32'h0);
        exp_q.push_back(e_reg(5'd6, 32'hCD, 3'd2));
        bus.q_j_id = 3'd1; bus.q_k_id = 3'd2;
        bus.rs_rdy = 1'b1; bus.rs_rob_id = 3'd1; bus.rs_data = 32'hAB; bus.rs_set_jump_addr = 1'b0;
        bus.lsb_rdy = 1'b1; bus.lsb_rob_id = 3'd2; bus.lsb_data = 32'hCD;
        #1;
`ifdef ROB_QUERY_BYPASS_EN
        chk("byp_qj_ready", 32'(bus.q_j_ready), 32'd1);
        chk("byp_qj_data", bus.q_j_data, 32'hAB);
        chk("byp_qk_ready", 32'(bus.q_k_ready), 32'd1);
        chk("byp_qk_data", bus.q_k_data, 32'hCD);
`else
        chk("nobyp_qj_ready", 32'(bus.q_j_ready), 32'd0);
        chk("nobyp_qk_ready", 32'(bus.q_k_ready), 32'd0);
`endif
        tick();
        bus.rs_rdy = 1'b0; bus.lsb_rdy = 1'b0;
        #1;
        chk("q_qj_ready", 32'(bus.q_j_ready), 32'd1);
        chk("q_qj_data", bus.q_j_data, 32'hAB);
        chk("q_qk_ready", 32'(bus.q_k_ready), 32'd1);
        chk("q_qk_data", bus.q_k_data, 32'hCD);
        repeat (4) tick();

        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
